// File: rtl/npc_pkg.sv
// Shared definitions for the multicycle RV32I-subset core: encodings, FSM states,
// immediate formats and the decoded operation set.
package npc_pkg;

    localparam int          DATA_WIDTH  = 32;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        EXEC,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_I,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef enum logic [2:0] {
        OP_LUI,
        OP_AUIPC,
        OP_ADDI,
        OP_ADD,
        OP_SUB,
        OP_JAL,
        OP_JALR,
        OP_EBREAK
    } op_e;

    // Only instruction bits [31:12] ever carry immediate data for the supported formats.
    function automatic logic [31:0] gen_imm(input logic [31:12] hi, input imm_type_e t);
        logic [31:0] imm;
        imm = '0;
        case (t)
            IMM_I:   imm = {{20{hi[31]}}, hi[31:20]};
            IMM_U:   imm = {hi[31:12], 12'b0};
            IMM_J:   imm = {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_n.sv
// Register file with two asynchronous read ports and one write port; x0 reads as zero
// and ignores writes.
module regfile_n #(
    parameter int REG_ADDR_W = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i
);

    localparam int NREGS = 1 << REG_ADDR_W;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];

    // NOTE: the whole array sits on the async reset because the core must observe
    // all-zero registers after reset; this rules out mapping it onto reset-less RAM.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core: FETCH -> WAIT -> EXEC per instruction over a
// valid/ready fetch port, halting on ebreak or on any unsupported encoding.
module multicycle_core
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          REG_ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_val,
    output logic [31:0] ret_val,
    output logic        retire,
    output logic        halted,
    output logic        illegal
);

    localparam logic NARROW_RF = (REG_ADDR_W < 5);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ret_q, ret_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    op_e         op;
    imm_type_e   imm_t;
    logic        legal, use_rd, use_rs1, use_rs2;
    logic [31:0] imm, rs1_data, rs2_data, rd_wdata, pc_next, pc_plus4;
    logic        rf_we, req_valid_c, retire_c;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    always_comb begin
        op      = OP_EBREAK;
        imm_t   = IMM_NONE;
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (instr_q == EBREAK_INSN) begin
            legal = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    op = OP_LUI;   imm_t = IMM_U; legal = 1'b1; use_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    op = OP_AUIPC; imm_t = IMM_U; legal = 1'b1; use_rd = 1'b1;
                end
                OPC_OP_IMM: begin
                    op = OP_ADDI;  imm_t = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                    legal = (funct3 == F3_ADD);
                end
                OPC_OP: begin
                    op = (funct7 == F7_SUB) ? OP_SUB : OP_ADD;
                    use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    legal = (funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB));
                end
                OPC_JAL: begin
                    op = OP_JAL;   imm_t = IMM_J; legal = 1'b1; use_rd = 1'b1;
                end
                OPC_JALR: begin
                    op = OP_JALR;  imm_t = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                    legal = (funct3 == F3_ADD);
                end
                default: legal = 1'b0;
            endcase
            // A 16-entry file cannot name x16..x31.
            if (NARROW_RF && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]))) begin
                legal = 1'b0;
            end
        end
    end

    assign imm      = gen_imm(instr_q[31:12], imm_t);
    assign pc_plus4 = pc_q + 32'd4;

    // Operands are read combinationally before the write edge, so jalr with rd==rs1
    // naturally uses the old rs1.
    always_comb begin
        rd_wdata = '0;
        pc_next  = pc_plus4;
        case (op)
            OP_LUI:    rd_wdata = imm;
            OP_AUIPC:  rd_wdata = pc_q + imm;
            OP_ADDI:   rd_wdata = rs1_data + imm;
            OP_ADD:    rd_wdata = rs1_data + rs2_data;
            OP_SUB:    rd_wdata = rs1_data - rs2_data;
            OP_JAL: begin
                rd_wdata = pc_plus4;
                pc_next  = pc_q + imm;
            end
            OP_JALR: begin
                rd_wdata = pc_plus4;
                pc_next  = (rs1_data + imm) & ~32'd1;
            end
            default:   pc_next = pc_q;
        endcase
    end

    assign rf_we = (state_q == EXEC) && legal && use_rd;

    regfile_n #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst_ni    (rst),
        .raddr_a_i (instr_q[15 +: REG_ADDR_W]),
        .rdata_a_o (rs1_data),
        .raddr_b_i (instr_q[20 +: REG_ADDR_W]),
        .rdata_b_o (rs2_data),
        .we_i      (rf_we),
        .waddr_i   (instr_q[7 +: REG_ADDR_W]),
        .wdata_i   (rd_wdata)
    );

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        ret_d       = ret_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        req_valid_c = 1'b0;
        retire_c    = 1'b0;
        case (state_q)
            FETCH: begin
                req_valid_c = 1'b1;
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    retire_c = 1'b1;
                    pc_d     = pc_next;
                    if (rf_we && (rd == 5'd10)) ret_d = rd_wdata;
                    if (op == OP_EBREAK) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        state_d  = FETCH;
                    end
                end
            end
            default: state_d = HALT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            ret_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ret_q     <= ret_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // The FSM idles in FETCH during reset, so the request is gated off until release.
    assign imem_req_valid = req_valid_c & rst;
    assign imem_addr      = pc_q;
    assign pc_val         = pc_q;
    assign ret_val        = ret_q;
    assign retire         = retire_c & rst;
    assign halted         = halted_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: the bench plays instruction memory with
// programmable stalls and checks each instruction's effects against a queue of expectations.
module tb_multicycle_core;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_val, ret_val;
    logic        retire, halted, illegal;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic        retire;
        logic        halted;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    multicycle_core #(
        .RESET_PC   (RESET_PC),
        .REG_ADDR_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_val         (pc_val),
        .ret_val        (ret_val),
        .retire         (retire),
        .halted         (halted),
        .illegal        (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the core in FETCH; returns on the negedge after EXEC.
    task automatic step(input string tag, input logic [31:0] insn, input int rdy_stall,
                        input int rsp_stall, input logic [31:0] exp_pc, input logic [31:0] exp_ret,
                        input logic exp_retire, input logic exp_halted, input logic exp_illegal);
        exp_t        e;
        logic [31:0] addr0;
        exp_q.push_back('{pc: exp_pc, ret: exp_ret, retire: exp_retire,
                          halted: exp_halted, illegal: exp_illegal});
        check({tag, ".req_valid"}, {31'b0, imem_req_valid}, 32'd1);
        addr0 = imem_addr;
        for (int i = 0; i < rdy_stall; i++) begin
            @(negedge clk);
            check({tag, ".addr_stable"}, imem_addr, addr0);
            check({tag, ".req_held"}, {31'b0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check({tag, ".wait_no_req"}, {31'b0, imem_req_valid}, 32'd0);
        for (int i = 0; i < rsp_stall; i++) begin
            @(negedge clk);
            check({tag, ".wait_no_retire"}, {31'b0, retire}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = insn;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        e = exp_q.pop_front();
        check({tag, ".retire"}, {31'b0, retire}, {31'b0, e.retire});
        @(negedge clk);
        check({tag, ".pc"}, pc_val, e.pc);
        check({tag, ".ret_val"}, ret_val, e.ret);
        check({tag, ".halted"}, {31'b0, halted}, {31'b0, e.halted});
        check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e.illegal});
        check({tag, ".next_req"}, {31'b0, imem_req_valid},
              {31'b0, !(e.halted || e.illegal)});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, ".rst_pc"}, pc_val, RESET_PC);
        check({tag, ".rst_req"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, ".rst_ret"}, ret_val, 32'd0);
        check({tag, ".rst_flags"}, {29'b0, retire, halted, illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, ".post_rst_req"}, {31'b0, imem_req_valid}, 32'd1);
        check({tag, ".post_rst_pc"}, pc_val, RESET_PC);
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Zero-wait program, stalled fetches, jumps, x0 handling and PC wrap, ending on ebreak.
        do_reset("r0");
        step("lui",      32'h1234_5537, 0, 0, 32'h8000_0004, 32'h1234_5000, 1, 0, 0);
        step("addi",     32'h6785_0513, 0, 0, 32'h8000_0008, 32'h1234_5678, 1, 0, 0);
        step("stall94",  32'h0015_0513, 4, 2, 32'h8000_000C, 32'h1234_5679, 1, 0, 0);
        step("auipc",    32'h0000_1517, 1, 0, 32'h8000_0010, 32'h8000_100C, 1, 0, 0);
        step("lui_x1",   32'h8000_00B7, 0, 1, 32'h8000_0014, 32'h8000_100C, 1, 0, 0);
        step("addi_x1",  32'h0110_8093, 0, 0, 32'h8000_0018, 32'h8000_100C, 1, 0, 0);
        step("jalr",     32'h0040_80E7, 0, 0, 32'h8000_0014, 32'h8000_100C, 1, 0, 0);
        step("rd_x1",    32'h0000_8533, 0, 0, 32'h8000_0018, 32'h8000_001C, 1, 0, 0);
        step("jal",      32'h0080_006F, 0, 0, 32'h8000_0020, 32'h8000_001C, 1, 0, 0);
        step("sub",      32'h40A0_0533, 0, 0, 32'h8000_0024, 32'h7FFF_FFE4, 1, 0, 0);
        step("wr_x0",    32'h0050_0013, 0, 0, 32'h8000_0028, 32'h7FFF_FFE4, 1, 0, 0);
        step("rd_x0",    32'h0000_0533, 0, 0, 32'h8000_002C, 32'h0000_0000, 1, 0, 0);
        step("jalr_neg", 32'hFFC0_0067, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0);
        step("wrap",     32'h0030_0513, 0, 0, 32'h0000_0000, 32'h0000_0003, 1, 0, 0);
        step("ebreak",   32'h0010_0073, 0, 0, 32'h0000_0000, 32'h0000_0003, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            imem_rsp_valid = 1'b1;
            @(negedge clk);
            check("halt.req", {31'b0, imem_req_valid}, 32'd0);
            check("halt.retire", {31'b0, retire}, 32'd0);
            check("halt.pc", pc_val, 32'h0000_0000);
        end
        imem_rsp_valid = 1'b0;

        // Register index beyond a 16-entry file; x26 would alias x10 if written.
        do_reset("r1");
        step("ill_x17",  32'h0010_0893, 0, 0, RESET_PC, 32'h0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("ill_x17.req_after", {31'b0, imem_req_valid}, 32'd0);
        do_reset("r2");
        step("ill_x26",  32'h0010_0D13, 0, 0, RESET_PC, 32'h0, 0, 0, 1);

        // Reset during WAIT, then a stale response arriving after release.
        do_reset("r3");
        step("set_x1",   32'h0070_0093, 0, 0, 32'h8000_0004, 32'h0, 1, 0, 0);
        step("set_x10",  32'h1234_5537, 0, 0, 32'h8000_0008, 32'h1234_5000, 1, 0, 0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("mid.in_wait", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid.rst_pc", pc_val, RESET_PC);
        check("mid.rst_ret", ret_val, 32'd0);
        @(negedge clk);
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0015_0513;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale.req", {31'b0, imem_req_valid}, 32'd1);
            check("stale.retire", {31'b0, retire}, 32'd0);
            check("stale.pc", pc_val, RESET_PC);
        end
        imem_rsp_valid = 1'b0;
        step("cleared",  32'h00A0_8533, 0, 0, 32'h8000_0004, 32'h0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
